// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm tone path: detector state encoding and
// the default tone timing constants (also used for the sound generator's
// divider settings, so both ends of the loop agree on the expected tone).
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  localparam int unsigned DEF_HALF_MIN   = 4;
  localparam int unsigned DEF_HALF_MAX   = 6;
  localparam int unsigned DEF_LOCK_COUNT = 4;
  localparam int unsigned DEF_TIMEOUT    = 64;
  localparam int unsigned DEF_CNT_W      = 8;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, followed by a delay flop
// and a registered any-transition detector.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset
//   async_i - asynchronous input level
//   edge_o  - one-cycle pulse per rising or falling transition of async_i
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic edge_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;
  logic edge_q;

  // The transition flag is registered so that downstream logic sees it one
  // cycle after s2/s3 diverge; this keeps the compare off the metastable path.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      edge_q <= s2_q ^ s3_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/alarm_tone_detect.sv
// Loop-back monitor for the alarm tone: measures the spacing of transitions
// on tone_in and reports lock once enough consecutive half-periods fall in
// the accepted window.
// Ports:
//   clk          - clock
//   rst          - synchronous active-high reset
//   enable       - detector run enable (low forces IDLE, half_period holds)
//   tone_in      - asynchronous tone line
//   tone_present - high while locked
//   half_period  - last measured interval between transitions (clk cycles)
//   period_valid - one-cycle pulse when half_period updates
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no reference transition yet
// ACQUIRE  | counting consecutive in-window half-periods
// LOCKED   | tone confirmed, stays while half-periods remain in window
module alarm_tone_detect
  import alarm_pkg::*;
#(
  parameter int unsigned HALF_MIN   = DEF_HALF_MIN,
  parameter int unsigned HALF_MAX   = DEF_HALF_MAX,
  parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             tone_in,
  output logic             tone_present,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid
);

  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]   HALF_MIN_C = CNT_W'(HALF_MIN);
  localparam logic [CNT_W-1:0]   HALF_MAX_C = CNT_W'(HALF_MAX);
  localparam logic [CNT_W-1:0]   TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [MATCH_W-1:0] LOCK_C     = MATCH_W'(LOCK_COUNT);

  logic               tone_edge;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  state_e             state_q, state_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MATCH_W-1:0] match_inc;
  logic [CNT_W-1:0]   half_q, half_d;
  logic               valid_q, valid_d;
  logic               present_q, present_d;
  logic               in_win;
  logic               timeout;

  sync_edge u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (tone_in),
    .edge_o  (tone_edge)
  );

  // cnt holds the cycles elapsed since the last transition, so on a new
  // transition its current value is the measured interval.
  assign in_win    = (cnt_q >= HALF_MIN_C) && (cnt_q <= HALF_MAX_C);
  // A transition landing on the saturation cycle wins over the timeout.
  assign timeout   = (cnt_q == TIMEOUT_C) && !tone_edge;
  assign match_inc = match_q + MATCH_W'(1);

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    match_d = match_q;
    half_d  = half_q;
    valid_d = 1'b0;

    if (!enable) begin
      cnt_d   = '0;
      state_d = ST_IDLE;
      match_d = '0;
    end else begin
      if (tone_edge) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q < TIMEOUT_C) begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      unique case (state_q)
        ST_IDLE: begin
          if (tone_edge) begin
            state_d = ST_ACQUIRE;
            match_d = '0;
          end
        end
        ST_ACQUIRE, ST_LOCKED: begin
          if (tone_edge) begin
            valid_d = 1'b1;
            half_d  = cnt_q;
            if (in_win) begin
              if (state_q == ST_ACQUIRE) begin
                match_d = match_inc;
                if (match_inc == LOCK_C) begin
                  state_d = ST_LOCKED;
                end
              end
            end else begin
              match_d = '0;
              state_d = ST_ACQUIRE;
            end
          end else if (timeout) begin
            state_d = ST_IDLE;
            match_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          match_d = '0;
        end
      endcase
    end

    // Taken from the next state so lock shows in the same cycle as the
    // pulse of the measurement that completed it.
    present_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
      match_q   <= '0;
      half_q    <= '0;
      valid_q   <= 1'b0;
      present_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      match_q   <= match_d;
      half_q    <= half_d;
      valid_q   <= valid_d;
      present_q <= present_d;
    end
  end

  assign tone_present = present_q;
  assign half_period  = half_q;
  assign period_valid = valid_q;

endmodule

// File: tb/tb_alarm_tone_detect.sv
module tb_alarm_tone_detect;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       tone_in;
  logic       tone_present;
  logic       period_valid;
  logic [7:0] half_period;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_half[$];
  logic       q_tp[$];
  int         eh[8];
  int         et[8];
  int         fall_at;

  always #5 clk = ~clk;

  alarm_tone_detect dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .tone_in      (tone_in),
    .tone_present (tone_present),
    .half_period  (half_period),
    .period_valid (period_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One cycle, sampled at the falling edge; every pulse is logged.
  task automatic step();
    @(negedge clk);
    if (period_valid === 1'b1) begin
      q_half.push_back(half_period);
      q_tp.push_back(tone_present);
    end
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic toggle_run(input int p);
    tone_in = ~tone_in;
    steps(p);
  endtask

  task automatic tone_seq(input int p, input int n);
    repeat (n) toggle_run(p);
  endtask

  task automatic clear_q();
    q_half.delete();
    q_tp.delete();
  endtask

  // Compare the logged pulses against eh/et (first n entries) and clear.
  task automatic chk_q(input string tag, input int n);
    chk({tag, "_count"}, q_half.size(), n);
    for (int i = 0; i < n && i < q_half.size(); i++) begin
      chk($sformatf("%s_half%0d", tag, i), q_half[i], eh[i]);
      chk($sformatf("%s_tp%0d", tag, i), q_tp[i], et[i]);
    end
    clear_q();
  endtask

  initial begin
    rst     = 1'b1;
    enable  = 1'b0;
    tone_in = 1'b0;

    // reset holds every output at zero while the line moves
    for (int i = 0; i < 3; i++) begin
      if (i == 1) tone_in = 1'b1;
      step();
      chk($sformatf("rst_tp%0d", i), tone_present, 0);
      chk($sformatf("rst_half%0d", i), half_period, 0);
      chk($sformatf("rst_pv%0d", i), period_valid, 0);
    end
    tone_in = 1'b0;
    rst     = 1'b0;
    enable  = 1'b1;
    steps(6);
    clear_q();

    // slow tone: reference edge then four measurements of 9, never locks
    tone_seq(9, 5);
    eh = '{9, 9, 9, 9, 0, 0, 0, 0};
    et = '{0, 0, 0, 0, 0, 0, 0, 0};
    chk_q("slow", 4);
    chk("slow_tp_end", tone_present, 0);

    // fast tone: first interval is still 9, then 3s; idle long enough to drop to IDLE
    tone_seq(3, 5);
    steps(80);
    eh = '{9, 3, 3, 3, 3, 0, 0, 0};
    et = '{0, 0, 0, 0, 0, 0, 0, 0};
    chk_q("fast", 5);
    chk("fast_tp_end", tone_present, 0);

    // lock: reference edge plus four in-window intervals of 5
    tone_seq(5, 5);
    eh = '{5, 5, 5, 5, 0, 0, 0, 0};
    et = '{0, 0, 0, 1, 0, 0, 0, 0};
    chk_q("lock", 4);
    chk("lock_tp_end", tone_present, 1);

    // loss of tone: lock drops 68 falling edges after the last toggle
    // (5 already consumed by the lock sequence)
    fall_at = -1;
    for (int k = 1; k <= 100 && fall_at < 0; k++) begin
      step();
      if (tone_present === 1'b0) fall_at = k;
    end
    chk("loss_fall_step", fall_at, 63);
    chk("loss_pulses", q_half.size(), 0);
    clear_q();

    // glitch: relock, then intervals 5,2,3,5,5,5,5
    tone_seq(5, 5);
    chk("relock_tp", tone_present, 1);
    clear_q();
    toggle_run(2);
    toggle_run(3);
    tone_seq(5, 5);
    eh = '{5, 2, 3, 5, 5, 5, 5, 0};
    et = '{1, 0, 0, 0, 0, 0, 1, 0};
    chk_q("glitch", 7);
    chk("glitch_tp_end", tone_present, 1);

    // disable for 10 cycles: lock drops at once, half_period holds
    enable = 1'b0;
    step();
    chk("dis_tp", tone_present, 0);
    chk("dis_pv", period_valid, 0);
    chk("dis_half", half_period, 5);
    steps(9);
    chk("dis_half_end", half_period, 5);
    chk("dis_pulses", q_half.size(), 0);
    clear_q();
    enable = 1'b1;
    tone_seq(5, 5);
    eh = '{5, 5, 5, 5, 0, 0, 0, 0};
    et = '{0, 0, 0, 1, 0, 0, 0, 0};
    chk_q("reen", 4);

    // reset while locked
    rst = 1'b1;
    step();
    chk("midrst_tp", tone_present, 0);
    chk("midrst_half", half_period, 0);
    chk("midrst_pv", period_valid, 0);
    rst = 1'b0;
    steps(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
